mem_access_unit: RTL and testbench

Load/store initiator for the multi-cycle MIPS datapath, on the opposite side of the word-wide data memory interface. It accepts one load/store request at a time from the control FSM and turns it into a sequence of memory read and write cycles. It adds byte and halfword access on top of the word-only memory: sub-word loads are extracted and extended, and sub-word stores use read-modify-write. Data is big-endian, so byte 0 is bits [31:24].

---
 rtl/mem_access_pkg.sv | 39 +++
 rtl/mem_access_unit_byte_lane_unit.sv | 51 +++++
 rtl/mem_access_unit.sv | 114 +++++++++++
 tb/tb_mem_access_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the load/store initiator: op encoding, FSM states, big-endian lane constants.
// Misalignment detection is only used when MEM_ACCESS_MISALIGN_CHECK_EN is defined.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Byte/halfword lane 0 occupies the most significant bits (big-endian).
    localparam int BYTE0_MSB = 31;
    localparam int HALF0_MSB = 31;

    function automatic logic is_store(input op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_unit.sv
// Combinational lane logic: extracts/extends sub-word loads and merges sub-word stores
// into the word read back from memory.
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  op_e         i_op,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]  w_bmsb;
    logic [4:0]  w_hmsb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword lane uses addr[1] only, so an odd halfword address still picks an aligned half.
    assign w_bmsb = 5'(BYTE0_MSB) - {i_addr_lo, 3'b000};
    assign w_hmsb = 5'(HALF0_MSB) - {i_addr_lo[1], 4'b0000};
    assign w_byte = i_word[w_bmsb -: 8];
    assign w_half = i_word[w_hmsb -: 16];

    always_comb begin
        o_load = i_word;
        case (i_op)
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'h0, w_byte};
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'h0, w_half};
            default: o_load = i_word;
        endcase
    end

    always_comb begin
        o_merged = i_wdata;
        case (i_op)
            OP_SB: begin
                o_merged = i_word;
                o_merged[w_bmsb -: 8] = i_wdata[7:0];
            end
            OP_SH: begin
                o_merged = i_word;
                o_merged[w_hmsb -: 16] = i_wdata[15:0];
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator over a word-only memory; sub-word stores use read-modify-write.
// Define MEM_ACCESS_MISALIGN_CHECK_EN to fail misaligned accesses with err instead of a memory cycle.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            r_state, w_next;
    op_e               r_op;
    logic [1:0]        r_addr_lo;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    op_e               w_op;
    logic              w_misalign;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;

    assign w_op = op_e'(op);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    logic r_err;
    assign w_misalign = is_misaligned(w_op, addr[1:0]);
    assign err        = (r_state == S_DONE) && r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_err <= 1'b0;
        else if (r_state == S_IDLE && req) r_err <= w_misalign;
    end
`else
    assign w_misalign = 1'b0;
    assign err        = 1'b0;
`endif

    byte_lane_unit u_lane (
        .i_word    (mem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_op      (r_op),
        .i_wdata   (r_wdata),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req) begin
                if (w_misalign)         w_next = S_DONE;
                else if (w_op == OP_SW) w_next = S_WR;
                else                    w_next = S_RD;
            end
            S_RD:    w_next = is_store(r_op) ? S_WR : S_DONE;
            S_WR:    w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LW;
            r_addr_lo   <= 2'b00;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (req) begin
                    r_op      <= w_op;
                    r_addr_lo <= addr[1:0];
                    r_wdata   <= wdata;
                    // mem_addr only moves when a memory cycle will actually follow.
                    if (!w_misalign) r_mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                    if (!w_misalign && w_op == OP_SW) r_mem_wdata <= wdata;
                end
                S_RD: begin
                    if (is_store(r_op)) r_mem_wdata <= w_merged;
                    else                r_rdata     <= w_load;
                end
                default: ;
            endcase
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign ack       = (r_state == S_DONE);
    assign mem_read  = (r_state == S_RD);
    assign mem_write = (r_state == S_WR);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expectations, a monitor checks acks.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        ready, ack, err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_read, mem_write;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:15];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_mem = 0;
    logic [31:0] last_rd = 32'h0;

    mem_access_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        mem[4] <= 32'h11223344;
        mem[5] <= 32'h8899AABB;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    end

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_read || mem_write) n_mem++;
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL rw_overlap: mem_read and mem_write both high at cycle %0d", cyc);
        end
        if (rst_n && ack) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack: ack at cycle %0d with nothing outstanding", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks += 3;
                if (rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rdata: got %h expected %h", rdata, e.rdata);
                end
                if (err !== e.err) begin
                    errors++;
                    $display("FAIL err: got %b expected %b", err, e.err);
                end
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL latency: ack at cycle %0d expected %0d", cyc, e.due);
                end
            end
        end
    end

    task automatic issue(input op_e o, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 10) begin @(negedge clk); n++; end
        req = 1'b1; op = o; addr = a; wdata = wd;
        e.rdata = exp_rd; e.err = exp_err; e.due = cyc + lat;
        sb.push_back(e);
        last_rd = exp_rd;
        @(posedge clk); #1 req = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 12) begin @(negedge clk); #1; n++; end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: op %0d addr %h never acked", o, a);
            sb.delete();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    initial begin
        int n;
        int m0;
        rst_n = 1'b0; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_ctl", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        issue(OP_LB,  32'h14, 32'h0, 32'hFFFFFF88, 1'b0, 2);
        issue(OP_LBU, 32'h14, 32'h0, 32'h00000088, 1'b0, 2);
        issue(OP_LH,  32'h16, 32'h0, 32'hFFFFAABB, 1'b0, 2);
        issue(OP_LHU, 32'h12, 32'h0, 32'h00003344, 1'b0, 2);
        issue(OP_LB,  32'h17, 32'h0, 32'hFFFFFFBB, 1'b0, 2);
        issue(OP_LBU, 32'h15, 32'h0, 32'h00000099, 1'b0, 2);
        issue(OP_LH,  32'h14, 32'h0, 32'hFFFF8899, 1'b0, 2);
        issue(OP_LHU, 32'h10, 32'h0, 32'h00001122, 1'b0, 2);
        issue(OP_LW,  32'h14, 32'h0, 32'h8899AABB, 1'b0, 2);
        chk("mem_addr_hold", mem_addr, 32'h14);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        m0 = n_mem;
        issue(OP_LW, 32'h13, 32'h0, last_rd, 1'b1, 1);
        issue(OP_SH, 32'h11, 32'hBEEF, last_rd, 1'b1, 1);
        issue(OP_SW, 32'h12, 32'hDEADBEEF, last_rd, 1'b1, 1);
        chk("misalign_no_mem", n_mem, m0);
        chk("misalign_mem_unchanged", mem[4], 32'h11223344);
`else
        issue(OP_LW, 32'h13, 32'h0, 32'h11223344, 1'b0, 2);
        issue(OP_LH, 32'h17, 32'h0, 32'hFFFFAABB, 1'b0, 2);
`endif

        issue(OP_SB, 32'h11, 32'h0000005A, last_rd, 1'b0, 3);
        chk("sb_mem", mem[4], 32'h115A3344);
        issue(OP_SW, 32'h10, 32'h11223344, last_rd, 1'b0, 2);
        chk("sw_mem", mem[4], 32'h11223344);
        issue(OP_SH, 32'h12, 32'h0000BEEF, last_rd, 1'b0, 3);
        chk("sh_mem", mem[4], 32'h1122BEEF);
        issue(OP_LW, 32'h10, 32'h0, 32'h1122BEEF, 1'b0, 2);
        issue(OP_SB, 32'h17, 32'hFFFFFF01, last_rd, 1'b0, 3);
        chk("sb_lane3_mem", mem[5], 32'h8899AA01);

        // Abort an SB during its WR cycle; memory must keep its old word.
        @(negedge clk);
        req = 1'b1; op = OP_SB; addr = 32'h10; wdata = 32'h0000005A;
        @(posedge clk); #1 req = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mem_write && n < 10) begin @(negedge clk); n++; end
        chk("abort_reached_wr", {31'h0, mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'h0, ready}, 32'h1);
        chk("abort_mem_ctl", {30'h0, mem_read, mem_write}, 32'h0);
        chk("abort_ack", {31'h0, ack}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_mem_unchanged", mem[4], 32'h1122BEEF);
        rst_n = 1'b1;
        last_rd = 32'h0;

        issue(OP_LW, 32'h10, 32'h0, 32'h1122BEEF, 1'b0, 2);
        issue(OP_LB, 32'h12, 32'h0, 32'hFFFFFFBE, 1'b0, 2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
